// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package reg_wb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_REG = 16;
  localparam int unsigned REG_W   = $clog2(NUM_REG);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StHold
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: two ordered push slots and one pop per cycle.
// With WB_FORWARD_EN the raw storage and read pointer are exposed for forwarding.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push0_i,
  input  wb_entry_t        entry0_i,
  input  logic             push1_i,
  input  wb_entry_t        entry1_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
`ifdef WB_FORWARD_EN
  output wb_entry_t        entries_o [DEPTH],
  output logic [PTR_W-1:0] rd_ptr_o,
`endif
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_idx1;

  always_comb begin
    // slot 1 lands right behind slot 0 only when slot 0 is used
    wr_idx1  = wr_ptr_q + PTR_W'(push0_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push0_i) mem_q[wr_ptr_q] <= entry0_i;
    if (push1_i) mem_q[wr_idx1]  <= entry1_i;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(pop_i && count_q == '0));
      assert (int'(count_q) + int'(push0_i) + int'(push1_i) <= int'(DEPTH));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
`ifdef WB_FORWARD_EN
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
`endif

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and load results into the register-file write port with a RAW scoreboard.
// Optional WB_FORWARD_EN adds per-source forwarding of the youngest queued value.
module reg_writeback_unit
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rf_ready,
  output logic              rf_write,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_writedata,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
`ifdef WB_FORWARD_EN
  output logic              rs1_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs2_fwd_data,
`endif
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned PEND_W = $clog2(DEPTH + 2);

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  free;
  wb_entry_t         head;
  wb_entry_t         entry0, entry1;
  logic              push0, push1, pop, retire;

  wb_state_e         state_q, state_d;
  logic              rf_write_q, rf_write_d;
  logic [REG_W-1:0]  rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_writedata_q, rf_writedata_d;

  logic [PEND_W-1:0] pend_q [NUM_REG];
  logic [PEND_W-1:0] pend_d [NUM_REG];

`ifdef WB_FORWARD_EN
  wb_entry_t         fifo_entries [DEPTH];
  logic [PTR_W-1:0]  fifo_rd_ptr;
`endif

  // Ready comes from the registered count, so a slot freed by this cycle's pop is not reused.
  always_comb begin
    free      = CNT_W'(DEPTH) - fifo_count;
    mem_ready = (free != '0);
    alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid);
    entry0    = '{rd: mem_rd, data: mem_data};
    entry1    = '{rd: alu_rd, data: alu_data};
    push0     = mem_valid && mem_ready && (mem_rd != '0);
    push1     = alu_valid && alu_ready && (alu_rd != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push0_i   (push0),
    .entry0_i  (entry0),
    .push1_i   (push1),
    .entry1_i  (entry1),
    .pop_i     (pop),
    .head_o    (head),
`ifdef WB_FORWARD_EN
    .entries_o (fifo_entries),
    .rd_ptr_o  (fifo_rd_ptr),
`endif
    .count_o   (fifo_count)
  );

  always_comb begin
    retire         = (state_q != StIdle) && rf_ready;
    pop            = (fifo_count != '0) && ((state_q == StIdle) || retire);
    state_d        = state_q;
    rf_write_d     = rf_write_q;
    rf_rd_d        = rf_rd_q;
    rf_writedata_d = rf_writedata_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d        = StWrite;
          rf_write_d     = 1'b1;
          rf_rd_d        = head.rd;
          rf_writedata_d = head.data;
        end
      end
      StWrite, StHold: begin
        if (!rf_ready) begin
          state_d = StHold;
        end else if (pop) begin
          state_d        = StWrite;
          rf_write_d     = 1'b1;
          rf_rd_d        = head.rd;
          rf_writedata_d = head.data;
        end else begin
          state_d    = StIdle;
          rf_write_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        rf_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      rf_write_q     <= 1'b0;
      rf_rd_q        <= '0;
      rf_writedata_q <= '0;
    end else begin
      state_q        <= state_d;
      rf_write_q     <= rf_write_d;
      rf_rd_q        <= rf_rd_d;
      rf_writedata_q <= rf_writedata_d;
    end
  end

  assign rf_write     = rf_write_q;
  assign rf_rd        = rf_rd_q;
  assign rf_writedata = rf_writedata_q;
  assign count        = fifo_count;

  // Both producers may target the same register in one cycle, hence up to +2.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REG; r++) begin
      pend_d[r] = pend_q[r];
      if (r != 0) begin
        if (push0 && entry0.rd == REG_W'(r)) pend_d[r] = pend_d[r] + PEND_W'(1);
        if (push1 && entry1.rd == REG_W'(r)) pend_d[r] = pend_d[r] + PEND_W'(1);
        if (retire && rf_rd_q == REG_W'(r))  pend_d[r] = pend_d[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned r = 0; r < NUM_REG; r++) begin
      if (reset) pend_q[r] <= '0;
      else       pend_q[r] <= pend_d[r];
    end
  end

`ifdef WB_FORWARD_EN
  logic [REG_W-1:0]  rs_idx    [2];
  logic [1:0]        fwd_valid;
  logic [DATA_W-1:0] fwd_data  [2];

  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;

  // Output regs are oldest, then queue head to tail; later matches win.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fwd_valid[s] = 1'b0;
      fwd_data[s]  = '0;
      if (rs_idx[s] != '0) begin
        if (rf_write_q && rf_rd_q == rs_idx[s]) begin
          fwd_valid[s] = 1'b1;
          fwd_data[s]  = rf_writedata_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if ((CNT_W'(i) < fifo_count) &&
              (fifo_entries[fifo_rd_ptr + PTR_W'(i)].rd == rs_idx[s])) begin
            fwd_valid[s] = 1'b1;
            fwd_data[s]  = fifo_entries[fifo_rd_ptr + PTR_W'(i)].data;
          end
        end
      end
    end
  end

  assign rs1_fwd_valid = fwd_valid[0];
  assign rs1_fwd_data  = fwd_data[0];
  assign rs2_fwd_valid = fwd_valid[1];
  assign rs2_fwd_data  = fwd_data[1];
  assign rs1_busy = (rs1 != '0) && (pend_q[rs1] != '0) && !fwd_valid[0];
  assign rs2_busy = (rs2 != '0) && (pend_q[rs2] != '0) && !fwd_valid[1];
`else
  assign rs1_busy = (rs1 != '0) && (pend_q[rs1] != '0);
  assign rs2_busy = (rs2 != '0) && (pend_q[rs2] != '0);
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit (DEPTH=4); forwarding checks under WB_FORWARD_EN.
module tb_reg_writeback_unit;

  logic        clock;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        rf_ready, rf_write;
  logic [3:0]  rf_rd;
  logic [15:0] rf_writedata;
  logic [3:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [2:0]  count;
`ifdef WB_FORWARD_EN
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [15:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  reg_writeback_unit #(
    .DEPTH (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .rf_ready      (rf_ready),
    .rf_write      (rf_write),
    .rf_rd         (rf_rd),
    .rf_writedata  (rf_writedata),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
`ifdef WB_FORWARD_EN
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data),
`endif
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rf_ready = 1'b1; rs1 = '0; rs2 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_write", rf_write, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_writedata, 0);
    chk("rst_count", count, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);

    // single ALU write to r3
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234; rs1 = 4'd3;
    #1 chk("t1_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t1_count", count, 1);
    chk("t1_busy_queued", rs1_busy, 1);
    chk("t1_no_write_yet", rf_write, 0);
    tick();
    chk("t1_write", rf_write, 1);
    chk("t1_rd", rf_rd, 3);
    chk("t1_data", rf_writedata, 16'h1234);
    chk("t1_busy_port", rs1_busy, 1);
    tick();
    chk("t1_idle", rf_write, 0);
    chk("t1_busy_clr", rs1_busy, 0);

    // simultaneous push: load goes first
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h5555; rs2 = 4'd5;
    #1;
    chk("t2_mem_ready", mem_ready, 1);
    chk("t2_alu_ready", alu_ready, 1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("t2_count", count, 2);
    chk("t2_busy", rs2_busy, 1);
    tick();
    chk("t2_first_rd", rf_rd, 5);
    chk("t2_first_data", rf_writedata, 16'hAAAA);
    chk("t2_count1", count, 1);
    tick();
    chk("t2_second_wr", rf_write, 1);
    chk("t2_second_rd", rf_rd, 6);
    chk("t2_second_data", rf_writedata, 16'h5555);
    chk("t2_busy_clr", rs2_busy, 0);
    tick();
    chk("t2_idle", rf_write, 0);

    // stall the port while writing r7 and fill the queue
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h0077;
    tick();
    alu_valid = 1'b0;
    tick();
    rf_ready = 1'b0;
    chk("t3_write_r7", rf_rd, 7);
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 16'h0808;
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h0909;
    tick();
    chk("t3_hold1_wr", rf_write, 1);
    chk("t3_hold1_rd", rf_rd, 7);
    chk("t3_hold1_data", rf_writedata, 16'h0077);
    mem_rd = 4'd10; mem_data = 16'h1010;
    alu_rd = 4'd11; alu_data = 16'h1111;
    #1;
    chk("t3_ready_free2_mem", mem_ready, 1);
    chk("t3_ready_free2_alu", alu_ready, 1);
    tick();
    chk("t3_full_count", count, 4);
    chk("t3_hold2_rd", rf_rd, 7);
    chk("t3_hold2_data", rf_writedata, 16'h0077);
    mem_rd = 4'd14; mem_data = 16'hEEEE;
    alu_rd = 4'd14; alu_data = 16'hEEEE;
    #1;
    chk("t3_full_mem_ready", mem_ready, 0);
    chk("t3_full_alu_ready", alu_ready, 0);
    mem_valid = 1'b0; alu_valid = 1'b0;
    tick();
    chk("t3_hold3_wr", rf_write, 1);
    chk("t3_hold3_rd", rf_rd, 7);
    chk("t3_hold3_data", rf_writedata, 16'h0077);
    chk("t3_hold3_count", count, 4);

    // full + pop: slot not reusable until next cycle, then free==1 arbitration
    rf_ready = 1'b1;
    #1 chk("t4_full_pop_ready", mem_ready, 0);
    tick();
    chk("t4_rd8", rf_rd, 8);
    chk("t4_data8", rf_writedata, 16'h0808);
    chk("t4_count3", count, 3);
    mem_valid = 1'b1; mem_rd = 4'd12; mem_data = 16'hC0C0;
    alu_valid = 1'b1; alu_rd = 4'd13; alu_data = 16'hD0D0;
    #1;
    chk("t4_free1_mem_ready", mem_ready, 1);
    chk("t4_free1_alu_ready", alu_ready, 0);
    tick();
    mem_valid = 1'b0;
    chk("t4_rd9", rf_rd, 9);
    chk("t4_count_a", count, 3);
    #1 chk("t4_alu_ready_next", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t4_rd10", rf_rd, 10);
    chk("t4_count_b", count, 3);
    tick();
    chk("t4_rd11", rf_rd, 11);
    chk("t4_count_c", count, 2);
    tick();
    chk("t4_rd12", rf_rd, 12);
    chk("t4_data12", rf_writedata, 16'hC0C0);
    tick();
    chk("t4_rd13", rf_rd, 13);
    chk("t4_data13", rf_writedata, 16'hD0D0);
    chk("t4_count_empty", count, 0);
    tick();
    chk("t4_idle", rf_write, 0);

    // rd==0 is accepted and dropped
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hFFFF; rs1 = 4'd0;
    #1 chk("t5_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_busy0", rs1_busy, 0);
    tick();
    chk("t5_no_write", rf_write, 0);

    // two writes to r4, reset mid-drain
    mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 16'h0A0A;
    alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 16'h0B0B; rs1 = 4'd4;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("t6_count2", count, 2);
`ifndef WB_FORWARD_EN
    chk("t6_busy_queued", rs1_busy, 1);
`endif
    tick();
    chk("t6_write", rf_write, 1);
    chk("t6_rd", rf_rd, 4);
    chk("t6_data", rf_writedata, 16'h0A0A);
    chk("t6_count1", count, 1);
`ifdef WB_FORWARD_EN
    chk("t6_fwd_valid", rs1_fwd_valid, 1);
    chk("t6_fwd_youngest", rs1_fwd_data, 16'h0B0B);
    chk("t6_busy_suppressed", rs1_busy, 0);
`else
    chk("t6_busy_port", rs1_busy, 1);
`endif
    reset = 1'b1;
    tick();
    chk("t6_rst_write", rf_write, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_busy", rs1_busy, 0);
    chk("t6_rst_rd", rf_rd, 0);
    reset = 1'b0;
    tick();
    chk("t6_after_write", rf_write, 0);
    chk("t6_after_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
